// File: rtl/pent_dram_seq_if.sv
// DRAM sequencer strobe bundle: CPU request in, RAS/CAS/MUX/refresh/WAIT strobes out.
// The master modport is the sequencer; the slave modport is the steering logic/CPU side.
interface pent_dram_seq_if #(
  parameter int REF_ROWS_W = 7
);
  logic                  CPU_MREQ_n;
  logic                  RAS;
  logic                  CAS_n;
  logic                  MUX;
  logic                  RFS;
  logic                  VID;
  logic [REF_ROWS_W-1:0] RA;
  logic                  RA_OE;
  logic                  WAIT_n;

  modport master (
    input  CPU_MREQ_n,
    output RAS, CAS_n, MUX, RFS, VID, RA, RA_OE, WAIT_n
  );

  modport slave (
    output CPU_MREQ_n,
    input  RAS, CAS_n, MUX, RFS, VID, RA, RA_OE, WAIT_n
  );
endinterface

// File: rtl/pent_dram_seq.sv
// Pentagon DRAM sequencer: alternating 4-clock video/CPU slots with RAS-only refresh
// stolen from idle CPU slots, forced (with WAIT) once deferred too long. All outputs registered.
module pent_dram_seq #(
  parameter int REF_INTERVAL  = 54,
  parameter int REF_MAX_DEFER = 4,
  parameter int REF_ROWS_W    = 7
) (
  input  logic            CLK,
  input  logic            RST,
  pent_dram_seq_if.master bus
);
  typedef enum logic [1:0] {P0 = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3} phase_e;

  localparam logic [7:0] CNT_LAST  = 8'(REF_INTERVAL - 1);
  localparam logic [3:0] DEFER_MAX = 4'(REF_MAX_DEFER);

  phase_e                phase_q, phase_d;
  logic                  vid_q, vid_d;
  logic                  ref_q, ref_d;
  logic                  frc_q, frc_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            owed_q, owed_d;
  logic [3:0]            defer_q, defer_d;
  logic [REF_ROWS_W-1:0] ra_q, ra_d;
  logic                  ras_q, ras_d;
  logic                  cas_n_q, cas_n_d;
  logic                  mux_q, mux_d;
  logic                  rfs_q, rfs_d;
  logic                  ra_oe_q, ra_oe_d;
  logic                  wait_n_q, wait_n_d;

  logic slot_end;
  logic tick;
  logic done;

  assign slot_end = (phase_q == P3);
  assign tick     = slot_end && (cnt_q == CNT_LAST);
  assign done     = slot_end && ref_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q  <= P0;
      vid_q    <= 1'b1;
      ref_q    <= 1'b0;
      frc_q    <= 1'b0;
      cnt_q    <= '0;
      owed_q   <= '0;
      defer_q  <= '0;
      ra_q     <= '0;
      ras_q    <= 1'b0;
      cas_n_q  <= 1'b1;
      mux_q    <= 1'b0;
      rfs_q    <= 1'b1;
      ra_oe_q  <= 1'b0;
      wait_n_q <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      vid_q    <= vid_d;
      ref_q    <= ref_d;
      frc_q    <= frc_d;
      cnt_q    <= cnt_d;
      owed_q   <= owed_d;
      defer_q  <= defer_d;
      ra_q     <= ra_d;
      ras_q    <= ras_d;
      cas_n_q  <= cas_n_d;
      mux_q    <= mux_d;
      rfs_q    <= rfs_d;
      ra_oe_q  <= ra_oe_d;
      wait_n_q <= wait_n_d;
    end
  end

  always_comb begin
    phase_d = P0;
    vid_d   = vid_q;
    ref_d   = ref_q;
    frc_d   = frc_q;
    cnt_d   = cnt_q;
    owed_d  = owed_q;
    defer_d = defer_q;
    ra_d    = ra_q;

    unique case (phase_q)
      P0:      phase_d = P1;
      P1:      phase_d = P2;
      P2:      phase_d = P3;
      default: phase_d = P0;
    endcase

    if (slot_end) begin
      vid_d = !vid_q;
      cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
      ref_d = 1'b0;
      frc_d = 1'b0;
      if (done) begin
        ra_d = ra_q + REF_ROWS_W'(1);
      end
      // Leaving a video slot decides what the following CPU slot will be.
      if (vid_q && (owed_q != 2'd0)) begin
        if (bus.CPU_MREQ_n) begin
          ref_d   = 1'b1;
          defer_d = 4'd0;
        end else if (defer_q == DEFER_MAX) begin
          ref_d   = 1'b1;
          frc_d   = 1'b1;
          defer_d = 4'd0;
        end else begin
          defer_d = defer_q + 4'd1;
        end
      end
    end

    unique case ({tick, done})
      2'b10:   owed_d = (owed_q == 2'd3) ? owed_q : owed_q + 2'd1;
      2'b01:   owed_d = owed_q - 2'd1;
      default: owed_d = owed_q;
    endcase

    if (owed_d == 2'd0) begin
      defer_d = 4'd0;
    end

    // Strobes are registered for the phase being entered.
    ras_d    = (phase_d != P0);
    mux_d    = !ref_d && ((phase_d == P2) || (phase_d == P3));
    cas_n_d  = ref_d || (phase_d != P3);
    rfs_d    = !ref_d;
    ra_oe_d  = ref_d;
    wait_n_d = !frc_d;
  end

  assign bus.RAS    = ras_q;
  assign bus.CAS_n  = cas_n_q;
  assign bus.MUX    = mux_q;
  assign bus.RFS    = rfs_q;
  assign bus.VID    = vid_q;
  assign bus.RA     = ra_q;
  assign bus.RA_OE  = ra_oe_q;
  assign bus.WAIT_n = wait_n_q;
endmodule
